// File: rtl/tc_ps_gp_pkg.sv
// Shared types and constants for the PS general-purpose AXI3 write-to-register-bank bridge.
// Holds the FSM state type, AXI burst encodings and the B-channel response codes.
package tc_ps_gp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] BEAT_BYTES  = 32'd4;

    // Byte mask of a WRAP container: (len+1)*4 - 1, i.e. {len, 2'b11}.
    function automatic logic [31:0] wrap_mask(input logic [3:0] len);
        return {26'd0, len, 2'b11};
    endfunction

endpackage

// File: rtl/tc_ps_gp_wr_agen.sv
// Next-beat address generator for 32-bit AXI3 write bursts.
// FIXED holds, INCR (and reserved 11) adds 4, WRAP adds 4 inside the aligned container.
module tc_ps_gp_wr_agen
    import tc_ps_gp_pkg::*;
(
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_burst,
    input  logic [3:0]  i_len,
    output logic [31:0] o_next
);

    logic [31:0] w_incr;
    logic [31:0] w_mask;

    assign w_incr = i_addr + BEAT_BYTES;
    assign w_mask = wrap_mask(i_len);

    always_comb begin
        o_next = w_incr;
        case (burst_t'(i_burst))
            BURST_FIXED: o_next = i_addr;
            BURST_WRAP:  o_next = (i_addr & ~w_mask) | (w_incr & w_mask);
            default:     o_next = w_incr;
        endcase
    end

endmodule

// File: rtl/tc_ps_gp_wr_ctl.sv
// AXI3 write slave on the PS GP0 port that turns accepted beats into single-cycle
// register-bank write strobes, with one outstanding transaction at a time.
module tc_ps_gp_wr_ctl
    import tc_ps_gp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter logic [31:0] ADDR_SPAN = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] M_AXI_GP0_0_awaddr,
    input  logic [1:0]  M_AXI_GP0_0_awburst,
    input  logic [3:0]  M_AXI_GP0_0_awcache,
    input  logic [11:0] M_AXI_GP0_0_awid,
    input  logic [3:0]  M_AXI_GP0_0_awlen,
    input  logic [1:0]  M_AXI_GP0_0_awlock,
    input  logic [2:0]  M_AXI_GP0_0_awprot,
    input  logic [3:0]  M_AXI_GP0_0_awqos,
    input  logic [2:0]  M_AXI_GP0_0_awsize,
    input  logic        M_AXI_GP0_0_awvalid,
    output logic        M_AXI_GP0_0_awready,

    input  logic [31:0] M_AXI_GP0_0_wdata,
    input  logic [11:0] M_AXI_GP0_0_wid,
    input  logic [3:0]  M_AXI_GP0_0_wstrb,
    input  logic        M_AXI_GP0_0_wlast,
    input  logic        M_AXI_GP0_0_wvalid,
    output logic        M_AXI_GP0_0_wready,

    output logic [11:0] M_AXI_GP0_0_bid,
    output logic [1:0]  M_AXI_GP0_0_bresp,
    output logic        M_AXI_GP0_0_bvalid,
    input  logic        M_AXI_GP0_0_bready,

    output logic [31:0] addr,
    output logic [31:0] data,
    output logic [3:0]  strb,
    output logic        wren
);

    wr_state_t   r_state;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic [11:0] r_bid;
    logic        r_wren;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_strb;

    logic [31:0] r_cur_addr;
    logic [1:0]  r_burst;
    logic [3:0]  r_len;
    logic [11:0] r_awid;
    logic [3:0]  r_beat;
    logic        r_err;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_last_beat;
    logic        w_in_win;
    logic        w_hit;
    logic        w_beat_err;
    logic [31:0] w_next_addr;
    logic        w_unused;

    // Protection/cache/QoS attributes carry no meaning for a register bank; size is always 4 bytes.
    assign w_unused = ^{M_AXI_GP0_0_awcache, M_AXI_GP0_0_awlock, M_AXI_GP0_0_awprot,
                        M_AXI_GP0_0_awqos, M_AXI_GP0_0_awsize};

    assign w_aw_hs     = r_awready & M_AXI_GP0_0_awvalid;
    assign w_w_hs      = r_wready & M_AXI_GP0_0_wvalid;
    assign w_last_beat = (r_beat == r_len);

    // Unsigned offset compare keeps the window test correct even if BASE_ADDR+ADDR_SPAN overflows.
    assign w_in_win    = (r_cur_addr - BASE_ADDR) < ADDR_SPAN;
    assign w_hit       = w_in_win & (M_AXI_GP0_0_wstrb != 4'd0);
    assign w_beat_err  = ~w_in_win
                       | (M_AXI_GP0_0_wlast != w_last_beat)
                       | (M_AXI_GP0_0_wid != r_awid);

    tc_ps_gp_wr_agen u_agen (
        .i_addr  (r_cur_addr),
        .i_burst (r_burst),
        .i_len   (r_len),
        .o_next  (w_next_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_bid      <= 12'd0;
            r_wren     <= 1'b0;
            r_addr     <= 32'd0;
            r_data     <= 32'd0;
            r_strb     <= 4'd0;
            r_cur_addr <= 32'd0;
            r_burst    <= 2'd0;
            r_len      <= 4'd0;
            r_awid     <= 12'd0;
            r_beat     <= 4'd0;
            r_err      <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            r_addr <= 32'd0;
            r_data <= 32'd0;
            r_strb <= 4'd0;

            case (r_state)
                ST_IDLE: begin
                    if (w_aw_hs) begin
                        r_cur_addr <= M_AXI_GP0_0_awaddr & ~32'd3;
                        r_burst    <= M_AXI_GP0_0_awburst;
                        r_len      <= M_AXI_GP0_0_awlen;
                        r_awid     <= M_AXI_GP0_0_awid;
                        r_beat     <= 4'd0;
                        r_err      <= 1'b0;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                        r_state    <= ST_DATA;
                    end else begin
                        r_awready  <= 1'b1;
                    end
                end

                ST_DATA: begin
                    if (w_w_hs) begin
                        r_wren     <= w_hit;
                        r_addr     <= w_hit ? r_cur_addr : 32'd0;
                        r_data     <= w_hit ? M_AXI_GP0_0_wdata : 32'd0;
                        r_strb     <= w_hit ? M_AXI_GP0_0_wstrb : 4'd0;
                        r_cur_addr <= w_next_addr;
                        r_beat     <= r_beat + 4'd1;
                        // Early wlast is only recorded as an error; the beat count alone ends the burst.
                        if (w_last_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_awid;
                            r_bresp  <= (r_err | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            r_state  <= ST_RESP;
                        end else begin
                            r_err    <= r_err | w_beat_err;
                        end
                    end
                end

                ST_RESP: begin
                    if (r_bvalid && M_AXI_GP0_0_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end

                default: begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign M_AXI_GP0_0_awready = r_awready;
    assign M_AXI_GP0_0_wready  = r_wready;
    assign M_AXI_GP0_0_bvalid  = r_bvalid;
    assign M_AXI_GP0_0_bresp   = r_bresp;
    assign M_AXI_GP0_0_bid     = r_bid;
    assign wren                = r_wren;
    assign addr                = r_addr;
    assign data                = r_data;
    assign strb                = r_strb;

endmodule
